sync_gen_param: RTL and testbench

- Parametrised successor to the fixed 1280x1024 VESA timing generator, for the cellular-automaton video path.
- Produces h/v sync with configurable polarity, display-enable, and pixel coordinates. Also produces a prefetch window a configurable number of clocks ahead of the visible area, so that memory/CA-row fetch latency is hidden.
- Adds a synchronous reset and line/frame strobes. Sits between the pixel clock domain root and the pixel pipeline / VGA pins.

---
 rtl/sync_gen_param.sv | 128 ++++++++++++
 tb/tb_sync_gen_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gen_param.sv
// sync_gen_param: parametrised video timing generator (visible-first layout).
// Produces h/v sync with selectable polarity, display enable, visible-aligned
// pixel coordinates, a prefetch window leading the display by PREFETCH clocks,
// and line/frame start strobes. All outputs are registered from the (cx,cy)
// held in the previous cycle.
// Optional macro SYNC_GEN_FRAME_CNT_EN adds a 16-bit frame_count output.
module sync_gen_param #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int PREFETCH = 0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          inDisplayArea,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic          inPrefetchArea,
  output logic [CW-1:0] prefetchCounterX,
  output logic [CW-1:0] prefetchCounterY,
  output logic          line_start,
  output logic          frame_start
`ifdef SYNC_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CW + 1;

  localparam logic [CW-1:0] HMAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VMAX = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSS  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSE  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSS  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSE  = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CW:0] PRE  = CW1'(PREFETCH);
  localparam logic [CW:0] HTOT = CW1'(H_TOTAL);

  localparam logic HON = (H_POL != 0);
  localparam logic VON = (V_POL != 0);

  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic [CW:0]   pxSum;
  logic          pxWrap;
  logic [CW-1:0] pxNext;
  logic [CW-1:0] pyNext;
  logic [CW-1:0] cyInc;

  // Raster position counters: cx wraps per line, cy advances on cx wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == HMAX) begin
      cx <= '0;
      cy <= cyInc;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  // Prefetch coordinate: cx+PREFETCH at CW+1 bits, carrying into the next line
  // (and next frame) when it runs past the end of the current line.
  always_comb begin
    cyInc  = (cy == VMAX) ? '0 : cy + 1'b1;
    pxSum  = {1'b0, cx} + PRE;
    pxWrap = (pxSum >= HTOT);
    pxNext = pxWrap ? CW'(pxSum - HTOT) : pxSum[CW-1:0];
    pyNext = pxWrap ? cyInc : cy;
  end

  // Registered outputs decoded from the current (cx,cy).
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_h_sync       <= ~HON;
      vga_v_sync       <= ~VON;
      inDisplayArea    <= 1'b0;
      counterX         <= '0;
      counterY         <= '0;
      inPrefetchArea   <= 1'b0;
      prefetchCounterX <= '0;
      prefetchCounterY <= '0;
      line_start       <= 1'b0;
      frame_start      <= 1'b0;
    end else begin
      vga_h_sync       <= (cx >= HSS && cx < HSE) ? HON : ~HON;
      vga_v_sync       <= (cy >= VSS && cy < VSE) ? VON : ~VON;
      inDisplayArea    <= (cx < HACT) && (cy < VACT);
      counterX         <= cx;
      counterY         <= cy;
      inPrefetchArea   <= (pxNext < HACT) && (pyNext < VACT);
      prefetchCounterX <= pxNext;
      prefetchCounterY <= pyNext;
      line_start       <= (cx == '0);
      frame_start      <= (cx == '0) && (cy == '0);
    end
  end

`ifdef SYNC_GEN_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_start, so it
  // already reads 1 while the first frame after reset is displayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (cx == '0 && cy == '0) begin
      frame_count <= frame_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_gen_param.sv
// tb_sync_gen_param: checks three small-timing instances of sync_gen_param
// (H 8/2/3/3, V 4/1/2/1): positive polarity, inverted polarity, and
// PREFETCH=2. Optional macro SYNC_GEN_FRAME_CNT_EN also checks frame_count.
module tb_sync_gen_param;

  localparam int HT  = 16;
  localparam int VT  = 8;
  localparam int FR  = HT * VT;
  localparam int HA  = 8;
  localparam int HSS = 10;
  localparam int HSE = 13;
  localparam int VA  = 4;
  localparam int VSS = 5;
  localparam int VSE = 7;

  typedef struct packed {
    int x;
    int y;
    int px;
    int py;
    bit de;
    bit pde;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } obs_t;

  typedef struct {
    bit rst;
    int adv;
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit ls;
    bit fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4:0] aX, aY, aPX, aPY;
  logic       aHS, aVS, aDE, aPDE, aLS, aFS;
  logic [4:0] bX, bY, bPX, bPY;
  logic       bHS, bVS, bDE, bPDE, bLS, bFS;
  logic [4:0] cX, cY, cPX, cPY;
  logic       cHS, cVS, cDE, cPDE, cLS, cFS;
`ifdef SYNC_GEN_FRAME_CNT_EN
  logic [15:0] aFC, bFC, cFC;
`endif

  int errors = 0;
  int checks = 0;
  bit inRst = 1'b1;
  int shown = 0;
  int nextN = 0;
  int fcExp = 0;

  always #5 clk = ~clk;

  sync_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .PREFETCH(0), .CW(5)
  ) dutA (
    .clk(clk), .rst(rst), .vga_h_sync(aHS), .vga_v_sync(aVS),
    .inDisplayArea(aDE), .counterX(aX), .counterY(aY),
    .inPrefetchArea(aPDE), .prefetchCounterX(aPX), .prefetchCounterY(aPY),
    .line_start(aLS), .frame_start(aFS)
`ifdef SYNC_GEN_FRAME_CNT_EN
    , .frame_count(aFC)
`endif
  );

  sync_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .PREFETCH(0), .CW(5)
  ) dutB (
    .clk(clk), .rst(rst), .vga_h_sync(bHS), .vga_v_sync(bVS),
    .inDisplayArea(bDE), .counterX(bX), .counterY(bY),
    .inPrefetchArea(bPDE), .prefetchCounterX(bPX), .prefetchCounterY(bPY),
    .line_start(bLS), .frame_start(bFS)
`ifdef SYNC_GEN_FRAME_CNT_EN
    , .frame_count(bFC)
`endif
  );

  sync_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .PREFETCH(2), .CW(5)
  ) dutC (
    .clk(clk), .rst(rst), .vga_h_sync(cHS), .vga_v_sync(cVS),
    .inDisplayArea(cDE), .counterX(cX), .counterY(cY),
    .inPrefetchArea(cPDE), .prefetchCounterX(cPX), .prefetchCounterY(cPY),
    .line_start(cLS), .frame_start(cFS)
`ifdef SYNC_GEN_FRAME_CNT_EN
    , .frame_count(cFC)
`endif
  );

  // Reference: pixel n after release maps linearly onto the raster; the
  // prefetch coordinate is simply the pixel PREFETCH positions further on.
  function automatic obs_t model(input bit r, input int n, input int pre,
                                 input bit hp, input bit vp);
    obs_t o;
    int m, q;
    o = '0;
    if (r) begin
      o.hs = ~hp;
      o.vs = ~vp;
      return o;
    end
    m = n % FR;
    q = (m + pre) % FR;
    o.x   = m % HT;
    o.y   = m / HT;
    o.px  = q % HT;
    o.py  = q / HT;
    o.de  = (o.x < HA) && (o.y < VA);
    o.pde = (o.px < HA) && (o.py < VA);
    o.hs  = (o.x >= HSS && o.x < HSE) ? hp : ~hp;
    o.vs  = (o.y >= VSS && o.y < VSE) ? vp : ~vp;
    o.ls  = (o.x == 0);
    o.fs  = (m == 0);
    return o;
  endfunction

  function automatic obs_t obsA();
    obs_t o;
    o.x = int'(aX); o.y = int'(aY); o.px = int'(aPX); o.py = int'(aPY);
    o.de = aDE; o.pde = aPDE; o.hs = aHS; o.vs = aVS; o.ls = aLS; o.fs = aFS;
    return o;
  endfunction

  function automatic obs_t obsB();
    obs_t o;
    o.x = int'(bX); o.y = int'(bY); o.px = int'(bPX); o.py = int'(bPY);
    o.de = bDE; o.pde = bPDE; o.hs = bHS; o.vs = bVS; o.ls = bLS; o.fs = bFS;
    return o;
  endfunction

  function automatic obs_t obsC();
    obs_t o;
    o.x = int'(cX); o.y = int'(cY); o.px = int'(cPX); o.py = int'(cPY);
    o.de = cDE; o.pde = cPDE; o.hs = cHS; o.vs = cVS; o.ls = cLS; o.fs = cFS;
    return o;
  endfunction

  task automatic checkObs(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d px=%0d py=%0d de=%0b pde=%0b hs=%0b vs=%0b ls=%0b fs=%0b; want x=%0d y=%0d px=%0d py=%0d de=%0b pde=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
               nm, a.x, a.y, a.px, a.py, a.de, a.pde, a.hs, a.vs, a.ls, a.fs,
               e.x, e.y, e.px, e.py, e.de, e.pde, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic checkVal(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One clock with rst driven to r; every instance is compared with the model.
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      inRst = 1'b1;
      nextN = 0;
    end else begin
      inRst = 1'b0;
      shown = nextN;
      nextN++;
    end
    checkObs("modelA", obsA(), model(inRst, shown, 0, 1'b1, 1'b1));
    checkObs("modelB", obsB(), model(inRst, shown, 0, 1'b0, 1'b0));
    checkObs("modelC", obsC(), model(inRst, shown, 2, 1'b1, 1'b1));
`ifdef SYNC_GEN_FRAME_CNT_EN
    if (r) fcExp = 0;
    else if (shown % FR == 0) fcExp = (fcExp + 1) % 65536;
    checkVal("frameCount", int'(aFC), fcExp);
`endif
  endtask

  function automatic vec_t mk(input int r, input int adv, input int x, input int y,
                              input int hs, input int vs, input int de,
                              input int ls, input int fs);
    vec_t v;
    v.rst = (r != 0); v.adv = adv; v.x = x; v.y = y;
    v.hs = (hs != 0); v.vs = (vs != 0); v.de = (de != 0);
    v.ls = (ls != 0); v.fs = (fs != 0);
    return v;
  endfunction

  vec_t vec[11];

  initial begin
    obs_t e;
    int cnt;
    bit found;

    //            rst adv  x  y hs vs de ls fs
    vec[0]  = mk(1,   3,  0, 0, 0, 0, 0, 0, 0);
    vec[1]  = mk(0,   1,  0, 0, 0, 0, 1, 1, 1);
    vec[2]  = mk(0,   7,  7, 0, 0, 0, 1, 0, 0);
    vec[3]  = mk(0,   1,  8, 0, 0, 0, 0, 0, 0);
    vec[4]  = mk(0,   2, 10, 0, 1, 0, 0, 0, 0);
    vec[5]  = mk(0,   2, 12, 0, 1, 0, 0, 0, 0);
    vec[6]  = mk(0,   1, 13, 0, 0, 0, 0, 0, 0);
    vec[7]  = mk(0,   3,  0, 1, 0, 0, 1, 1, 0);
    vec[8]  = mk(0,  64,  0, 5, 0, 1, 0, 1, 0);
    vec[9]  = mk(0,  32,  0, 7, 0, 0, 0, 1, 0);
    vec[10] = mk(0,  16,  0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < $size(vec); i++) begin
      for (int k = 0; k < vec[i].adv; k++) step(vec[i].rst);
      e = '0;
      e.x = vec[i].x; e.y = vec[i].y; e.px = vec[i].x; e.py = vec[i].y;
      e.hs = vec[i].hs; e.vs = vec[i].vs; e.de = vec[i].de; e.pde = vec[i].de;
      e.ls = vec[i].ls; e.fs = vec[i].fs;
      checkObs($sformatf("vec%0d", i), obsA(), e);
    end

    // Inverted polarities: both syncs sit at 1 while held in reset.
    step(1'b1);
    checkVal("polResetHs", int'(bHS), 1);
    checkVal("polResetVs", int'(bVS), 1);
    step(1'b0);

    // Display enable is high for 8 of the 16 clocks of a line.
    cnt = 0;
    for (int k = 0; k < HT; k++) begin
      cnt += int'(aDE);
      step(1'b0);
    end
    checkVal("deLine", cnt, 8);

    // frame_start period.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b0);
      if (aFS) found = 1'b1;
    end
    checkVal("fsFound", int'(found), 1);
    cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b0);
      cnt++;
      if (aFS) found = 1'b1;
    end
    checkVal("fsPeriod", cnt, FR);

    // Prefetch at the end of the frame wraps into row 0 and leads display by 2.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b0);
      if (int'(cX) == 14 && int'(cY) == 7) found = 1'b1;
    end
    checkVal("preFound", int'(found), 1);
    checkVal("preX14", int'(cPX), 0);
    checkVal("preYWrap", int'(cPY), 0);
    checkVal("prePdeLead", int'(cPDE), 1);
    checkVal("preDeLow", int'(cDE), 0);
    step(1'b0);
    checkVal("preDeStillLow", int'(cDE), 0);
    step(1'b0);
    checkVal("preDeRise", int'(cDE), 1);

    // Mid-frame reset at (5,2) aborts immediately.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b0);
      if (int'(aX) == 5 && int'(aY) == 2) found = 1'b1;
    end
    checkVal("midFound", int'(found), 1);
    step(1'b1);
    checkVal("midRstX", int'(aX), 0);
    checkVal("midRstDe", int'(aDE), 0);
    checkVal("midRstFs", int'(aFS), 0);
    checkVal("midRstHsB", int'(bHS), 1);
    step(1'b0);
    checkVal("midRelFs", int'(aFS), 1);
    checkVal("midRelX", int'(aX), 0);
    checkVal("midRelY", int'(aY), 0);

    // Random reset pulses against the model.
    for (int k = 0; k < 800; k++) step($urandom_range(0, 49) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
